// File: rtl/branch_flush_ctrl.sv
// -----------------------------------------------------------------------------
// branch_flush_ctrl
//
// Branch resolution and pipeline-redirect controller sitting beside EX.
// Owns the architectural NZCV flag register and decides whether the branch in
// EX is taken. A taken branch redirects the PC for one cycle and squashes the
// wrong-path instructions for FLUSH_CYCLES cycles. It also keeps a saturating
// count of taken branches.
//
// Parameters:
//   PC_W          width of PC / branch target
//   FLUSH_CYCLES  squash cycles after a taken branch (1..7)
//   CNT_W         width of the taken-branch counter
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   mem_stall     global freeze; every register holds
//   set_flags_ex  EX instruction writes NZCV
//   alu_neg/ovf/cout/zero  ALU flags from EX
//   br_valid      branch present in EX
//   br_type       00 B, 01 CBZ, 10 B.LT, 11 reserved
//   br_target     target of the EX branch
//   pc_sel        select redirect target at PC mux (first FLUSH cycle only)
//   pc_target     registered redirect target
//   flush_if_id   squash IF/ID
//   flush_id_ex   squash ID/EX
//   flags_q       {N,Z,C,V}
//   busy          high while in FLUSH
//   taken_cnt     saturating taken-branch count
// -----------------------------------------------------------------------------
module branch_flush_ctrl #(
    parameter int PC_W         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic             set_flags_ex,
    input  logic             alu_neg,
    input  logic             alu_ovf,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [PC_W-1:0]  br_target,
    output logic             pc_sel,
    output logic [PC_W-1:0]  pc_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [3:0]       flags_q,
    output logic             busy,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        BR_B    = 2'b00,
        BR_CBZ  = 2'b01,
        BR_LT   = 2'b10,
        BR_RSVD = 2'b11
    } br_type_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_pc_sel;      // doubles as the "first FLUSH cycle" flag
    logic [PC_W-1:0]  r_pc_target;
    logic             r_flush;
    logic             r_busy;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_cond;
    logic             w_take;

    // Take decision. B.LT looks only at the registered flags, so a flag write
    // in the same cycle does not affect the branch alongside it.
    always_comb begin
        // NOTE: default first so every path assigns w_cond and no latch is inferred.
        w_cond = 1'b0;
        case (br_type)
            BR_B:    w_cond = 1'b1;
            BR_CBZ:  w_cond = alu_zero;
            BR_LT:   w_cond = r_flags[3] ^ r_flags[0];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_take = br_valid & w_cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pc_sel    <= 1'b0;
            r_pc_target <= '0;
            r_flush     <= 1'b0;
            r_busy      <= 1'b0;
            r_flags     <= '0;
            r_taken_cnt <= '0;
        end else if (!mem_stall) begin
            // NOTE: non-blocking everywhere here, so every register samples the
            // pre-edge values (B.LT therefore sees the old flags).
            if (set_flags_ex) begin
                r_flags <= {alu_neg, alu_zero, alu_cout, alu_ovf};
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state     <= S_FLUSH;
                        r_cnt       <= CNT_INIT;
                        r_pc_sel    <= 1'b1;
                        r_pc_target <= br_target;
                        r_flush     <= 1'b1;
                        r_busy      <= 1'b1;
                        if (r_taken_cnt != {CNT_W{1'b1}}) begin
                            r_taken_cnt <= r_taken_cnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Branches seen here are wrong-path and ignored.
                    r_pc_sel <= 1'b0;
                    if (r_cnt == 3'd0) begin
                        r_state <= S_IDLE;
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc_sel      = r_pc_sel;
    assign pc_target   = r_pc_target;
    assign flush_if_id = r_flush;
    assign flush_id_ex = r_flush;
    assign busy        = r_busy;
    assign flags_q     = r_flags;
    assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
module tb_branch_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst, mem_stall, set_flags_ex;
    logic        alu_neg, alu_ovf, alu_cout, alu_zero;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [63:0] br_target;

    logic        pc_sel, flush_if_id, flush_id_ex, busy;
    logic [63:0] pc_target;
    logic [3:0]  flags_q;
    logic [31:0] taken_cnt;

    logic        s_pc_sel, s_flush_if_id, s_flush_id_ex, s_busy;
    logic [63:0] s_pc_target;
    logic [3:0]  s_flags_q;
    logic [3:0]  s_taken_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_flush_ctrl #(.PC_W(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .set_flags_ex(set_flags_ex),
        .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .br_valid(br_valid), .br_type(br_type), .br_target(br_target),
        .pc_sel(pc_sel), .pc_target(pc_target), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .flags_q(flags_q), .busy(busy), .taken_cnt(taken_cnt)
    );

    // Narrow-counter instance sharing the same stimulus.
    branch_flush_ctrl #(.PC_W(64), .FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .set_flags_ex(set_flags_ex),
        .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .br_valid(br_valid), .br_type(br_type), .br_target(br_target),
        .pc_sel(s_pc_sel), .pc_target(s_pc_target), .flush_if_id(s_flush_if_id),
        .flush_id_ex(s_flush_id_ex), .flags_q(s_flags_q), .busy(s_busy), .taken_cnt(s_taken_cnt)
    );

    typedef struct {
        logic        rst, stall, sf, n, v, c, z, bv;
        logic [1:0]  bt;
        logic [63:0] tgt;
        logic        e_sel;
        logic [63:0] e_tgt;
        logic        e_fl, e_busy;
        logic [3:0]  e_flags;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, st, sf, n, v, c, z, bv, input logic [1:0] bt, input logic [63:0] tgt,
        input logic e_sel, input logic [63:0] e_tgt, input logic e_fl, e_busy,
        input logic [3:0] e_flags, input logic [31:0] e_cnt);
        vec_t x;
        x.rst = r; x.stall = st; x.sf = sf; x.n = n; x.v = v; x.c = c; x.z = z;
        x.bv = bv; x.bt = bt; x.tgt = tgt;
        x.e_sel = e_sel; x.e_tgt = e_tgt; x.e_fl = e_fl; x.e_busy = e_busy;
        x.e_flags = e_flags; x.e_cnt = e_cnt;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, st, sf, n, v, c, z, bv,
                         input logic [1:0] bt, input logic [63:0] tgt);
        rst = r; mem_stall = st; set_flags_ex = sf;
        alu_neg = n; alu_ovf = v; alu_cout = c; alu_zero = z;
        br_valid = bv; br_type = bt; br_target = tgt;
    endtask

    // Apply inputs for one cycle, then sample just after the edge.
    task automatic cycle(input logic r, st, sf, n, v, c, z, bv,
                         input logic [1:0] bt, input logic [63:0] tgt);
        drive(r, st, sf, n, v, c, z, bv, bt, tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h0);
    endtask

    task automatic check_all(input string tag, input logic e_sel, input logic [63:0] e_tgt,
                             input logic e_fl, e_busy, input logic [3:0] e_flags,
                             input logic [31:0] e_cnt);
        check({tag, ".pc_sel"},      pc_sel,      e_sel);
        check({tag, ".pc_target"},   pc_target,   e_tgt);
        check({tag, ".flush_if_id"}, flush_if_id, e_fl);
        check({tag, ".flush_id_ex"}, flush_id_ex, e_fl);
        check({tag, ".busy"},        busy,        e_busy);
        check({tag, ".flags_q"},     flags_q,     e_flags);
        check({tag, ".taken_cnt"},   taken_cnt,   e_cnt);
    endtask

    initial begin
        int n_busy, n_sel;

        // rst st sf n v c z bv bt tgt | sel tgt fl busy flags cnt
        vecs.push_back(mk(1,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h0,  0,0,4'h0,0)); // reset
        vecs.push_back(mk(0,0,0,0,0,0,0,1,2'b00,64'h40,  1,64'h40, 1,1,4'h0,1)); // B taken
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h40, 1,1,4'h0,1)); // 2nd flush cycle
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h40, 0,0,4'h0,1)); // back to idle
        vecs.push_back(mk(0,0,1,1,0,0,0,0,2'b00,64'h0,   0,64'h40, 0,0,4'h8,1)); // flags N=1 V=0
        vecs.push_back(mk(0,0,0,0,0,0,0,1,2'b10,64'h80,  1,64'h80, 1,1,4'h8,2)); // B.LT taken
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h80, 1,1,4'h8,2));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h80, 0,0,4'h8,2));
        vecs.push_back(mk(0,0,1,1,1,0,0,0,2'b00,64'h0,   0,64'h80, 0,0,4'h9,2)); // flags N=1 V=1
        vecs.push_back(mk(0,0,0,0,0,0,0,1,2'b10,64'hC0,  0,64'h80, 0,0,4'h9,2)); // B.LT not taken
        vecs.push_back(mk(0,0,0,0,0,0,0,1,2'b01,64'h100, 0,64'h80, 0,0,4'h9,2)); // CBZ zero=0
        vecs.push_back(mk(0,0,0,0,0,0,1,1,2'b01,64'h100, 1,64'h100,1,1,4'h9,3)); // CBZ zero=1
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h100,1,1,4'h9,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h100,0,0,4'h9,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,2'b11,64'h200, 0,64'h100,0,0,4'h9,3)); // reserved
        vecs.push_back(mk(0,0,1,1,0,0,0,1,2'b10,64'h200, 0,64'h100,0,0,4'h8,3)); // B.LT uses old flags
        vecs.push_back(mk(0,0,0,0,0,0,0,1,2'b10,64'h240, 1,64'h240,1,1,4'h8,4)); // new flags next cycle
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h240,1,1,4'h8,4));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2'b00,64'h0,   0,64'h240,0,0,4'h8,4));
        vecs.push_back(mk(0,0,1,0,0,1,1,0,2'b00,64'h0,   0,64'h240,0,0,4'h6,4)); // Z,C ordering
        vecs.push_back(mk(0,1,1,1,1,0,0,1,2'b00,64'h280, 0,64'h240,0,0,4'h6,4)); // stall freezes all

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].stall, vecs[i].sf, vecs[i].n, vecs[i].v,
                  vecs[i].c, vecs[i].z, vecs[i].bv, vecs[i].bt, vecs[i].tgt);
            check_all($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_tgt,
                      vecs[i].e_fl, vecs[i].e_busy, vecs[i].e_flags, vecs[i].e_cnt);
        end

        // Taken B, branch during FLUSH ignored, 3-cycle stall mid-FLUSH.
        n_busy = 0;
        n_sel  = 0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0:       cycle(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 64'h300);
                1:       cycle(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 64'h340);
                2, 3, 4: cycle(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 64'h0);
                default: idle();
            endcase
            if (busy) n_busy++;
            if (pc_sel) n_sel++;
            if (k == 0) check("stall.first_target", pc_target, 64'h300);
            if (k == 4) check("stall.flush_held", flush_if_id, 1'b1);
        end
        check("stall.window_len", n_busy, 5);
        check("stall.pc_sel_len", n_sel, 1);
        check("stall.target_kept", pc_target, 64'h300);
        check("stall.cnt", taken_cnt, 5);

        // Reset asserted in the second FLUSH cycle.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 64'h400);
        check_all("rst.enter", 1, 64'h400, 1, 1, 4'h6, 6);
        idle();
        check_all("rst.second", 0, 64'h400, 1, 1, 4'h6, 6);
        cycle(1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 64'h480);
        check_all("rst.applied", 0, 64'h0, 0, 0, 4'h0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 64'h440);
        check_all("rst.after", 1, 64'h440, 1, 1, 4'h0, 1);
        idle();
        idle();
        check("rst.idle_busy", busy, 1'b0);

        // Saturation on the 4-bit instance: reset, then 17 taken branches.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h0);
        check("sat.reset", s_taken_cnt, 4'h0);
        for (int b = 1; b <= 17; b++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 64'h1000 + 64'(b));
            idle();
            idle();
            if (b == 15) check("sat.at15", s_taken_cnt, 4'hE + 4'h1);
            if (b == 16) check("sat.at16", s_taken_cnt, 4'hF);
            if (b == 17) check("sat.hold", s_taken_cnt, 4'hF);
        end
        check("sat.wide_cnt", taken_cnt, 17);
        check("sat.last_target", s_pc_target, 64'h1011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
